pc_tx_word_serialiser: RTL and testbench
========================================

PC_TX_WORD_SERIALISER -- requirements
Module: pc_tx_word_serialiser

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, the clock cycles per UART bit (50 MHz / 115200 baud).
REQ-002 The block SHALL have port i_clock  input  1  the single system clock; all logic is on the rising edge.
REQ-003 The block SHALL have port i_reset  input  1  asynchronous, active-low reset: low clears all state immediately.
REQ-004 The block SHALL have port i_data_word  input  32  word to transmit, valid when i_next_cmd=1.
REQ-005 The block SHALL have port i_next_cmd  input  1  write strobe: on each cycle it is high, push i_data_word.
REQ-006 The block SHALL have port o_busy  output  1  registered; high means the upstream shall not issue new words.
REQ-007 The block SHALL have port o_tx  output  1  UART 8N1 serial line, idle high.
REQ-008 The block SHALL have port o_tx_active  output  1  high while the FSM is not in IDLE.
REQ-009 The block SHALL have port o_word_done  output  1  one-cycle pulse after the stop bit of a word's 4th byte.
REQ-010 The block SHALL have port o_overflow  output  1  sticky flag, set when a write is dropped.

Function
REQ-011 The block SHALL buffer writes in an internal 4-word FIFO with a 3-bit occupancy count (0..4).
REQ-012 o_busy SHALL be registered high whenever the count is >=3 after the clock edge, so one late write after busy rises still fits.
REQ-013 A write while count=4 SHALL be dropped, leave the FIFO unchanged and set o_overflow to 1 until reset.
REQ-014 A same-cycle push and pop SHALL leave the count unchanged; at count=4 the push SHALL be accepted only if a pop occurs in that cycle.
REQ-015 The FSM SHALL have the states IDLE, LOAD, START, DATA and STOP.
REQ-016 IDLE -> LOAD SHALL occur when count>0.
REQ-017 LOAD (1 cycle, o_tx=1) SHALL pop the head word into a 32-bit shift register, set byte_idx=3 and go to START.
REQ-018 START SHALL drive o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
REQ-019 DATA SHALL drive the 8 bits of byte[byte_idx] LSB first, each for CLKS_PER_BIT cycles, then go to STOP.
REQ-020 Byte order SHALL be MSB byte first: byte 3 = bits 31:24, down to byte 0 = bits 7:0.
REQ-021 STOP SHALL drive o_tx=1 for CLKS_PER_BIT cycles; at its last cycle, if byte_idx>0, it SHALL decrement byte_idx and go to START.
REQ-022 Otherwise, at the last STOP cycle the FSM SHALL pulse o_word_done on the next cycle and go to LOAD if count>0, else to IDLE.
REQ-023 Back-to-back words SHALL have exactly one high cycle (LOAD) between the last stop bit and the next start bit.
REQ-024 Bytes within a word SHALL have no gap between them.
REQ-025 Latency: a write at edge k into an empty, idle block SHALL give LOAD during cycle k+1 and start bit (o_tx=0) from edge k+2.
REQ-026 One word SHALL occupy o_tx for exactly 40*CLKS_PER_BIT cycles.
REQ-027 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; its width SHALL be clog2(CLKS_PER_BIT).
REQ-028 The bit counter SHALL be 3 bits and the byte index 2 bits.
REQ-029 o_tx SHALL be registered and glitch-free.

Reset
REQ-030 While i_reset=0 the block SHALL hold o_tx=1, o_busy=0, o_tx_active=0, o_word_done=0 and o_overflow=0.
REQ-031 While i_reset=0 the FIFO count and pointers SHALL be 0, the FSM SHALL be in IDLE, and all counters SHALL be 0.
REQ-032 A reset asserted mid-word SHALL abort transmission immediately (o_tx=1), discard all buffered words, and produce no o_word_done.
REQ-033 The first write after reset deassertion SHALL be accepted normally.

Verification (CLKS_PER_BIT=4)
REQ-034 Reset: assert i_reset=0 with random inputs -> o_tx=1, o_busy=0, o_overflow=0, o_tx_active=0.
REQ-035 Single word: write 0xA1B2C3D4 -> o_tx carries bytes A1, B2, C3, D4 as 8N1 LSB first, start bit 2 cycles after the write, 160 cycles total, one o_word_done pulse.
REQ-036 Fill/overflow (FSM stalled in the first byte): 3 writes -> o_busy=1 after the 3rd edge; 4th write accepted (count=4); 5th dropped -> o_overflow=1 and the transmitted data is the first 4 words only.
REQ-037 Router-style: i_next_cmd high for 2 consecutive cycles at count=2 -> both words accepted, no overflow, o_busy=1.
REQ-038 Back-to-back: 2 queued words -> exactly one o_tx-high cycle between the 4th stop bit and the next start bit; two o_word_done pulses 161 cycles apart.
REQ-039 Mid-byte reset: i_reset=0 during DATA of byte 2 -> o_tx=1 at once, count=0, no o_word_done; after release, a new word transmits correctly.

Source files
------------

// File: rtl/pc_tx_word_serialiser.sv
// Word-to-UART serialiser: a 4-deep word FIFO feeding an 8N1 transmitter that
// sends each 32-bit word as four bytes, most significant byte first.
module pc_tx_word_serialiser #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_data_word,
  input  logic        i_next_cmd,
  output logic        o_busy,
  output logic        o_tx,
  output logic        o_tx_active,
  output logic        o_word_done,
  output logic        o_overflow,
  output logic [2:0]  o_state
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // Handshake: i_next_cmd is a write strobe with no ready. A strobe is taken
  // when the FIFO has room or is popped that cycle; otherwise it is dropped and
  // o_overflow latches. o_busy (count >= 3) asks the writer to stop early.
  logic [31:0]   mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count, count_next;
  logic          push, pop;

  logic [2:0]    state;
  logic [31:0]   shreg;
  logic [1:0]    byte_idx;
  logic [2:0]    bit_idx;
  logic [BW-1:0] baud_cnt;
  logic [7:0]    cur_byte;
  logic          baud_last;

  assign pop       = (state == S_LOAD);
  assign push      = i_next_cmd && ((count != 3'd4) || pop);
  assign cur_byte  = shreg[{byte_idx, 3'b000} +: 8];
  assign baud_last = (baud_cnt == BAUD_LAST);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 3'd1;
    else if (!push && pop)
      count_next = count - 3'd1;
  end

  always_ff @(posedge i_clock) begin
    if (push)
      mem[wr_ptr] <= i_data_word;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count  <= count_next;
      o_busy <= (count_next >= 3'd3);
      if (i_next_cmd && !push)
        o_overflow <= 1'b1;
    end
  end

  // o_tx is updated alongside each state change so the line is a plain flop.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      shreg       <= 32'd0;
      byte_idx    <= 2'd0;
      bit_idx     <= 3'd0;
      baud_cnt    <= '0;
      o_tx        <= 1'b1;
      o_word_done <= 1'b0;
    end else begin
      o_word_done <= 1'b0;
      case (state)
        S_IDLE: begin
          o_tx <= 1'b1;
          if (count != 3'd0)
            state <= S_LOAD;
        end
        S_LOAD: begin
          shreg    <= mem[rd_ptr];
          byte_idx <= 2'd3;
          baud_cnt <= '0;
          o_tx     <= 1'b0;
          state    <= S_START;
        end
        S_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            o_tx     <= cur_byte[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_tx  <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              o_tx    <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (byte_idx != 2'd0) begin
              byte_idx <= byte_idx - 2'd1;
              o_tx     <= 1'b0;
              state    <= S_START;
            end else begin
              o_word_done <= 1'b1;
              o_tx        <= 1'b1;
              state       <= (count != 3'd0) ? S_LOAD : S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          o_tx  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tx_active = (state != S_IDLE);
  assign o_state     = state;

endmodule

// File: tb/tb_pc_tx_word_serialiser.sv
// Bench for pc_tx_word_serialiser: random and directed writes checked every
// cycle against a timeline model of the FIFO and the 40-bit word frame.
module tb_pc_tx_word_serialiser;

  localparam int CPB   = 4;
  localparam int FRAME = 40 * CPB;

  logic        i_clock;
  logic        i_reset;
  logic [31:0] i_data_word;
  logic        i_next_cmd;
  logic        o_busy, o_tx, o_tx_active, o_word_done, o_overflow;
  logic [2:0]  dbg_state;

  pc_tx_word_serialiser #(.CLKS_PER_BIT(CPB)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_data_word (i_data_word),
    .i_next_cmd  (i_next_cmd),
    .o_busy      (o_busy),
    .o_tx        (o_tx),
    .o_tx_active (o_tx_active),
    .o_word_done (o_word_done),
    .o_overflow  (o_overflow),
    .o_state     (dbg_state)
  );

  // clock / reset
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_vec = 0;
  int n_err = 0;

  // reference model: buffered words, current frame word and cycle position
  logic [31:0] exp_q[$];
  logic [31:0] m_word;
  int          m_t;
  bit          m_load, m_ovf, m_done;

  logic        tx_log[$];
  int          done_idx[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [31:0] w, input int t);
    int b, p;
    logic [7:0] by;
    b  = t / (10 * CPB);
    p  = (t % (10 * CPB)) / CPB;
    by = w[8 * (3 - b) +: 8];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return by[p - 1];
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_t    = -1;
    m_load = 0;
    m_ovf  = 0;
    m_done = 0;
  endfunction

  function automatic void model_edge(input logic cmd, input logic [31:0] w);
    bit pop, push, was_free;
    int size_before;
    if (!i_reset) begin
      model_reset();
      return;
    end
    pop         = m_load;
    was_free    = (m_t == -1 && !m_load) || (m_t == FRAME - 1);
    size_before = exp_q.size();
    push        = cmd && (size_before < 4 || pop);
    if (cmd && !push) m_ovf = 1;
    m_done = 0;
    if (pop) begin
      m_word = exp_q.pop_front();
      m_t    = 0;
    end else if (m_t >= 0) begin
      m_t++;
      if (m_t == FRAME) begin
        m_t    = -1;
        m_done = 1;
      end
    end
    if (push) exp_q.push_back(w);
    m_load = was_free && (size_before > 0);
  endfunction

  task automatic check_outputs(input string pfx);
    logic etx;
    etx = (m_t >= 0) ? frame_bit(m_word, m_t) : 1'b1;
    check({pfx, "_tx"},     32'(o_tx),        32'(etx));
    check({pfx, "_busy"},   32'(o_busy),      32'(exp_q.size() >= 3));
    check({pfx, "_active"}, 32'(o_tx_active), 32'(m_t >= 0 || m_load));
    check({pfx, "_done"},   32'(o_word_done), 32'(m_done));
    check({pfx, "_ovf"},    32'(o_overflow),  32'(m_ovf));
    tx_log.push_back(o_tx);
    if (o_word_done) done_idx.push_back(tx_log.size() - 1);
  endtask

  // driver: apply inputs, clock once, update model, check at the falling edge
  task automatic step(input logic cmd, input logic [31:0] w);
    i_next_cmd  = cmd;
    i_data_word = w;
    @(posedge i_clock);
    model_edge(cmd, w);
    @(negedge i_clock);
    check_outputs("cyc");
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, $urandom);
  endtask

  task automatic do_reset(input int n);
    i_reset     = 1'b0;
    i_next_cmd  = 1'($urandom);
    i_data_word = $urandom;
    #1;
    model_reset();
    check_outputs("rst_now");
    repeat (n) step(1'($urandom_range(0, 1)), $urandom);
    i_reset = 1'b1;
  endtask

  task automatic decode_from(input int from, output int start, output logic [31:0] word);
    start = -1;
    word  = 32'd0;
    for (int i = from; i < tx_log.size(); i++) begin
      if (tx_log[i] == 1'b0) begin
        start = i;
        break;
      end
    end
    if (start < 0 || start + FRAME > tx_log.size()) return;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        word[8 * (3 - b) + i] = tx_log[start + (b * 10 + 1 + i) * CPB + CPB / 2];
  endtask

  initial begin
    int s, s2, idx_w, pos;
    logic [31:0] wd, wd2;
    logic [31:0] fw[6];
    int rate;

    i_reset     = 1'b0;
    i_next_cmd  = 1'b0;
    i_data_word = 32'd0;
    @(negedge i_clock);
    model_reset();
    check_outputs("por");
    do_reset(3);

    // single word
    tx_log.delete(); done_idx.delete();
    step(1'b1, 32'hA1B2C3D4);
    idx_w = tx_log.size() - 1;
    idle(FRAME + 10);
    decode_from(idx_w, s, wd);
    check("sw_latency", 32'(s - idx_w), 32'd2);
    check("sw_data", wd, 32'hA1B2C3D4);
    check("sw_done_cnt", 32'(done_idx.size()), 32'd1);
    if (done_idx.size() > 0) check("sw_done_at", 32'(done_idx[0] - s), 32'(FRAME));

    // fill and overflow while the first word is on the line
    do_reset(2);
    tx_log.delete(); done_idx.delete();
    for (int k = 0; k < 6; k++) fw[k] = $urandom;
    step(1'b1, fw[0]);
    idle(5);
    step(1'b1, fw[1]);
    step(1'b1, fw[2]);
    check("fill_busy_at2", 32'(o_busy), 32'd0);
    step(1'b1, fw[3]);
    check("fill_busy_at3", 32'(o_busy), 32'd1);
    step(1'b1, fw[4]);
    check("fill_ovf_at4", 32'(o_overflow), 32'd0);
    step(1'b1, fw[5]);
    check("fill_ovf_at5", 32'(o_overflow), 32'd1);
    idle(5 * (FRAME + 1) + 20);
    pos = 0;
    for (int k = 0; k < 5; k++) begin
      decode_from(pos, s, wd);
      check($sformatf("fill_word%0d", k), wd, fw[k]);
      pos = (s < 0) ? tx_log.size() : s + FRAME;
    end
    decode_from(pos, s, wd);
    check("fill_no_extra", 32'(s), 32'hFFFF_FFFF);

    // two writes in consecutive cycles starting at count 2
    do_reset(2);
    step(1'b1, $urandom);
    idle(4);
    step(1'b1, $urandom);
    step(1'b1, $urandom);
    step(1'b1, $urandom);
    step(1'b1, $urandom);
    check("router_ovf", 32'(o_overflow), 32'd0);
    check("router_busy", 32'(o_busy), 32'd1);
    idle(5 * (FRAME + 1) + 20);

    // back-to-back words
    do_reset(2);
    tx_log.delete(); done_idx.delete();
    fw[0] = $urandom; fw[1] = $urandom;
    step(1'b1, fw[0]);
    step(1'b1, fw[1]);
    idle(2 * FRAME + 20);
    decode_from(0, s, wd);
    decode_from(s + FRAME, s2, wd2);
    check("b2b_word0", wd, fw[0]);
    check("b2b_word1", wd2, fw[1]);
    check("b2b_gap", 32'(s2 - s), 32'(FRAME + 1));
    check("b2b_done_cnt", 32'(done_idx.size()), 32'd2);
    if (done_idx.size() == 2) check("b2b_done_gap", 32'(done_idx[1] - done_idx[0]), 32'(FRAME + 1));

    // reset in the data bits of the second byte, then a clean word
    do_reset(2);
    step(1'b1, $urandom);
    step(1'b1, $urandom);
    idle(2 + 10 * CPB + 5 * CPB);
    check("mid_active", 32'(o_tx_active), 32'd1);
    done_idx.delete();
    do_reset(4);
    check("mid_no_done", 32'(done_idx.size()), 32'd0);
    idle(3);
    tx_log.delete();
    fw[2] = $urandom;
    step(1'b1, fw[2]);
    idx_w = tx_log.size() - 1;
    idle(FRAME + 10);
    decode_from(idx_w, s, wd);
    check("post_rst_latency", 32'(s - idx_w), 32'd2);
    check("post_rst_data", wd, fw[2]);

    // random traffic at varying write rates
    do_reset(2);
    for (int ph = 0; ph < 8; ph++) begin
      case (ph % 4)
        0:       rate = 1;
        1:       rate = 3;
        2:       rate = 20;
        default: rate = 70;
      endcase
      repeat (500) step(1'($urandom_range(0, 99) < rate), $urandom);
    end
    idle(5 * (FRAME + 1) + 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
